// File: rtl/uart_byte_tx.sv
// Byte-level 8N1 UART transmitter: one byte per accepted wr_en, tx idles high.
// Define UART_BYTE_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_byte_tx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       wr_en,
    output logic       tx_busy,
    output logic       tx
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_BYTE_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             tx_reg, tx_next;
    logic             busy_reg, busy_next;
`ifdef UART_BYTE_TX_PARITY_EN
    logic             parity_reg, parity_next;
`endif

    logic baud_wrap;
    logic accept;

    assign baud_wrap = (cnt_reg == CNT_MAX);
    // Registered busy gates acceptance, so a write lands no earlier than one idle cycle after a frame.
    assign accept    = wr_en && !busy_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            shift_reg  <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
`ifdef UART_BYTE_TX_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            shift_reg  <= shift_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
`ifdef UART_BYTE_TX_PARITY_EN
            parity_reg <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = S_START;
            S_START:  if (baud_wrap) state_next = S_DATA;
            S_DATA: begin
                if (baud_wrap && idx_reg == 3'd7) begin
`ifdef UART_BYTE_TX_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_BYTE_TX_PARITY_EN
            S_PARITY: if (baud_wrap) state_next = S_STOP;
`endif
            S_STOP:   if (baud_wrap) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // tx is computed one cycle ahead so the line level comes straight from a flop.
    always_comb begin
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        shift_next  = shift_reg;
        tx_next     = tx_reg;
        busy_next   = busy_reg;
`ifdef UART_BYTE_TX_PARITY_EN
        parity_next = parity_reg;
`endif
        if (state_reg != S_IDLE) begin
            cnt_next = baud_wrap ? '0 : cnt_reg + 1'b1;
        end
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    shift_next  = data_in;
                    tx_next     = 1'b0;
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                    idx_next    = '0;
`ifdef UART_BYTE_TX_PARITY_EN
                    parity_next = ^data_in;
`endif
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    if (idx_reg == 3'd7) begin
                        idx_next = '0;
`ifdef UART_BYTE_TX_PARITY_EN
                        tx_next  = parity_reg;
`else
                        tx_next  = 1'b1;
`endif
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        tx_next    = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end
            end
`ifdef UART_BYTE_TX_PARITY_EN
            S_PARITY: begin
                if (baud_wrap) tx_next = 1'b1;
            end
`endif
            S_STOP: begin
                if (baud_wrap) busy_next = 1'b0;
            end
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

    assign tx      = tx_reg;
    assign tx_busy = busy_reg;

endmodule
